lsu_bank_ram: RTL and testbench

LSU_BANK_RAM -- requirements
Module: lsu_bank_ram

---
 rtl/lsu_bank_ram.sv | 177 +++++++++++++++++
 tb/tb_lsu_bank_ram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bank_ram.sv
// Banked 32-bit data RAM serving MIPS-style byte/half/word/unaligned loads and stores.
// Each request takes WAIT_CYCLES wait states followed by a single-cycle response pulse.
module lsu_bank_ram #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SWL = 4'd11;
   localparam logic [3:0] OP_SWR = 4'd12;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [3:0]          op_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                exec;
   logic [3:0]          x_op;
   logic [ADDR_W+1:0]   x_addr;
   logic [31:0]         x_wdata;
   logic [1:0]          x_off;
   logic [ADDR_W-1:0]   x_idx;
   logic [31:0]         st_word;
   logic [3:0]          st_mask;
   logic [31:0]         rd_word;
   logic [31:0]         ld_data;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [1:0]          q_off;
   logic                q_err;
   logic                unused_addr;

   function automatic logic op_err(input logic [3:0] op, input logic [1:0] off);
      case (op)
         OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR, OP_SWL, OP_SWR: op_err = 1'b0;
         OP_LH, OP_LHU, OP_SH:                                 op_err = off[0];
         OP_LW, OP_SW:                                         op_err = (off != 2'd0);
         default:                                              op_err = 1'b1;
      endcase
   endfunction

   assign req_ready   = (state_q == ST_IDLE);
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exec    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cnt_d = WAIT_INIT;
               if (WAIT_CYCLES == 0) begin
                  exec    = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               exec    = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_IDLE && req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
         end
      end
   end

   // With zero wait states the access happens on the accept edge, so use the live request.
   assign x_op    = (state_q == ST_IDLE) ? req_op : op_q;
   assign x_addr  = (state_q == ST_IDLE) ? req_addr[ADDR_W+1:0] : addr_q;
   assign x_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
   assign x_off   = x_addr[1:0];
   assign x_idx   = x_addr[ADDR_W+1:2];

   always_comb begin
      st_word = '0;
      st_mask = '0;
      case (x_op)
         OP_SB:  begin st_word = {4{x_wdata[7:0]}};  st_mask = 4'b0001 << x_off;  end
         OP_SH:  begin st_word = {2{x_wdata[15:0]}}; st_mask = 4'b0011 << x_off;  end
         OP_SW:  begin st_word = x_wdata;            st_mask = 4'b1111;           end
         OP_SWL: begin st_word = x_wdata >> {x_off, 3'b000};  st_mask = 4'b1111 << x_off;  end
         OP_SWR: begin st_word = x_wdata << {~x_off, 3'b000}; st_mask = 4'b1111 >> ~x_off; end
         default: ;
      endcase
      if (!exec || rst || op_err(x_op, x_off))
         st_mask = '0;
   end

   // Mask bit gi selects bank gi, which holds big-endian byte offset gi.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [7:0] bank_q [DEPTH];
         logic [7:0] rd_q;
         always_ff @(posedge clk) begin
            if (st_mask[gi])
               bank_q[x_idx] <= st_word[31-8*gi -: 8];
            rd_q <= bank_q[x_idx];
         end
         assign rd_word[31-8*gi -: 8] = rd_q;
      end
   endgenerate

   assign q_off   = addr_q[1:0];
   assign q_err   = op_err(op_q, q_off);
   assign ld_byte = 8'(rd_word >> {~q_off, 3'b000});
   assign ld_half = 16'(rd_word >> (q_off[1] ? 5'd0 : 5'd16));

   always_comb begin
      ld_data = '0;
      case (op_q)
         OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_data = {24'd0, ld_byte};
         OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU: ld_data = {16'd0, ld_half};
         OP_LW:  ld_data = rd_word;
         OP_LWL: ld_data = (rd_word << {q_off, 3'b000}) |
                           (wdata_q & ~(32'hFFFF_FFFF << {q_off, 3'b000}));
         OP_LWR: ld_data = (rd_word >> {~q_off, 3'b000}) |
                           (wdata_q & ~(32'hFFFF_FFFF >> {~q_off, 3'b000}));
         default: ;
      endcase
   end

   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = resp_valid && q_err;
   assign resp_rdata = (resp_valid && !q_err) ? ld_data : 32'd0;

endmodule

// File: tb/tb_lsu_bank_ram.sv
// Drives two lsu_bank_ram instances (2 and 0 wait states) with identical requests and
// checks both against a byte-addressed big-endian memory model.
module tb_lsu_bank_ram;
   localparam int WA = 2;
   localparam int WB = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
   logic [31:0] rdata_a, rdata_b;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  mem_m [2][4096];
   logic [31:0] last_a, last_b;
   logic        last_ea;

   always #5 clk = ~clk;

   lsu_bank_ram #(.ADDR_W(10), .WAIT_CYCLES(WA)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(valid_a), .resp_rdata(rdata_a), .resp_err(err_a));

   lsu_bank_ram #(.ADDR_W(10), .WAIT_CYCLES(WB)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(valid_b), .resp_rdata(rdata_b), .resp_err(err_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: memory is a flat byte array, byte address a holds byte a of the big-endian word.
   task automatic model(input int d, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, output logic [31:0] rd, output logic err);
      int a, base, n;
      logic [31:0] word, v;
      logic [15:0] h;
      a    = int'(addr[11:0]);
      base = a - (a % 4);
      n    = a % 4;
      word = {mem_m[d][base], mem_m[d][base+1], mem_m[d][base+2], mem_m[d][base+3]};
      h    = {mem_m[d][a], mem_m[d][(a+1) % 4096]};
      rd   = 32'd0;
      case (op)
         4'd2, 4'd3, 4'd9:                          err = addr[0];
         4'd4, 4'd10:                               err = (n != 0);
         4'd0, 4'd1, 4'd5, 4'd6, 4'd8, 4'd11, 4'd12: err = 1'b0;
         default:                                   err = 1'b1;
      endcase
      if (!err) begin
         case (op)
            4'd0: rd = {{24{mem_m[d][a][7]}}, mem_m[d][a]};
            4'd1: rd = {24'd0, mem_m[d][a]};
            4'd2: rd = {{16{h[15]}}, h};
            4'd3: rd = {16'd0, h};
            4'd4: rd = word;
            4'd5: rd = (word << (8*n)) | (rt & ~(32'hFFFF_FFFF << (8*n)));
            4'd6: rd = (word >> (8*(3-n))) | (rt & ~(32'hFFFF_FFFF >> (8*(3-n))));
            4'd8: mem_m[d][a] = rt[7:0];
            4'd9: begin mem_m[d][a] = rt[15:8]; mem_m[d][a+1] = rt[7:0]; end
            4'd10: for (int k = 0; k < 4; k++) mem_m[d][base+k] = 8'(rt >> (8*(3-k)));
            4'd11: begin
               v = rt >> (8*n);
               for (int k = n; k < 4; k++) mem_m[d][base+k] = 8'(v >> (8*(3-k)));
            end
            4'd12: begin
               v = rt << (8*(3-n));
               for (int k = 0; k <= n; k++) mem_m[d][base+k] = 8'(v >> (8*(3-k)));
            end
            default: ;
         endcase
      end
   endtask

   task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] exp_a, exp_b, rd_a, rd_b;
      logic        ee_a, ee_b, e_a, e_b;
      int          lat_a, lat_b, np_a, np_b, nlow;
      model(0, op, addr, wd, exp_a, ee_a);
      model(1, op, addr, wd, exp_b, ee_b);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat_a = 0; lat_b = 0; np_a = 0; np_b = 0; nlow = 0;
      rd_a = '0; rd_b = '0; e_a = 1'b0; e_b = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (valid_a) begin
            np_a++;
            if (lat_a == 0) begin lat_a = c; rd_a = rdata_a; e_a = err_a; end
         end
         if (valid_b) begin
            np_b++;
            if (lat_b == 0) begin lat_b = c; rd_b = rdata_b; e_b = err_b; end
         end
         if (!ready_a) nlow++;
      end
      chk("lat_a", 32'(lat_a), 32'(WA + 1));
      chk("lat_b", 32'(lat_b), 32'(WB + 1));
      chk("pulse_a", 32'(np_a), 32'd1);
      chk("pulse_b", 32'(np_b), 32'd1);
      chk("busy_a", 32'(nlow), 32'(WA + 1));
      chk("rdata_a", rd_a, exp_a);
      chk("err_a", {31'd0, e_a}, {31'd0, ee_a});
      chk("rdata_b", rd_b, exp_b);
      chk("err_b", {31'd0, e_b}, {31'd0, ee_b});
      last_a = rd_a; last_b = rd_b; last_ea = e_a;
      $display("txn op=%0d addr=%h wd=%h -> a=%h/%0d b=%h/%0d", op, addr, wd, rd_a, e_a, rd_b, e_b);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd7, 4'd13};
      logic [31:0] dummy;
      logic        de;
      int          np;

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4096; i++) mem_m[d][i] = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
      chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
      chk("rst_err_a", {31'd0, err_a}, 32'd0);
      chk("rst_rdata_a", rdata_a, 32'd0);
      chk("rst_ready_b", {31'd0, ready_b}, 32'd1);

      for (int w = 0; w < 16; w++) run_txn(4'd10, 32'(w * 4), 32'd0);

      run_txn(4'd10, 32'h8, 32'h4455_6677);
      run_txn(4'd4, 32'h8, 32'd0);        chk("sw_lw", last_a, 32'h4455_6677);
      run_txn(4'd0, 32'h8, 32'd0);        chk("lb_8", last_a, 32'h0000_0044);
      run_txn(4'd3, 32'hA, 32'd0);        chk("lhu_a", last_a, 32'h0000_6677);

      run_txn(4'd8, 32'h3, 32'hFF);
      run_txn(4'd0, 32'h3, 32'd0);        chk("lb_3", last_a, 32'hFFFF_FFFF);
      run_txn(4'd1, 32'h3, 32'd0);        chk("lbu_3", last_a, 32'h0000_00FF);
      run_txn(4'd2, 32'h2, 32'd0);        chk("lh_2", last_a, 32'h0000_00FF);

      run_txn(4'd5, 32'h9, 32'hAABB_CCDD); chk("lwl_9", last_a, 32'h5566_77DD);
      run_txn(4'd6, 32'h9, 32'hAABB_CCDD); chk("lwr_9", last_a, 32'hAABB_4455);
      run_txn(4'd11, 32'h9, 32'hAABB_CCDD);
      run_txn(4'd4, 32'h8, 32'd0);        chk("swl_lw", last_a, 32'h44AA_BBCC);

      run_txn(4'd4, 32'h6, 32'd0);        chk("lw6_err", {31'd0, last_ea}, 32'd1);
      chk("lw6_rdata", last_a, 32'd0);
      run_txn(4'd9, 32'h5, 32'hFFFF);     chk("sh5_err", {31'd0, last_ea}, 32'd1);
      run_txn(4'd4, 32'h4, 32'd0);        chk("w4_intact", last_a, 32'd0);
      run_txn(4'd4, 32'h0, 32'd0);        chk("w0_intact", last_a, 32'h0000_00FF);
      run_txn(4'd7, 32'h10, 32'd0);       chk("op7_err", {31'd0, last_ea}, 32'd1);
      run_txn(4'd15, 32'h10, 32'd0);      chk("op15_err", {31'd0, last_ea}, 32'd1);

      run_txn(4'd10, 32'h1234_5010, 32'hDEAD_BEEF);
      run_txn(4'd4, 32'h10, 32'd0);       chk("wrap_lw", last_a, 32'hDEAD_BEEF);

      // Reset lands while dut_a waits; dut_b has already written on the accept edge.
      run_txn(4'd10, 32'h0, 32'hCAFE_F00D);
      model(1, 4'd10, 32'h0, 32'h1234_5678, dummy, de);
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd10; req_addr = 32'h0; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_wait_a", {31'd0, ready_a}, 32'd0);
      chk("abort_resp_b", {31'd0, valid_b}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      np = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("post_rst_ready", {31'd0, ready_a}, 32'd1);
            chk("post_rst_rdata", rdata_a, 32'd0);
         end
         if (valid_a) np++;
      end
      chk("abort_no_resp", 32'(np), 32'd0);
      run_txn(4'd4, 32'h0, 32'd0);
      chk("abort_no_write", last_a, 32'hCAFE_F00D);
      chk("b_written", last_b, 32'h1234_5678);

      for (int i = 0; i < 150; i++)
         run_txn(ops[$urandom_range(0, 13)],
                 ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
